// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
// Define RFARB_FORWARD_EN to add write-through forwarding of the staged write to two read ports.
module regfile_write_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int CNT_W       = 16,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluReg,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memReg,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
`ifdef RFARB_FORWARD_EN
  input  logic [ADDR_W-1:0] readRegister1,
  input  logic [ADDR_W-1:0] readRegister2,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2,
`endif
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic [CNT_W-1:0]  conflictCount
);

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } grantState_t;

  grantState_t       stateReg;
  grantState_t       stateNext;
  logic              aluXfer;
  logic              memXfer;
  logic              aluDrop;
  logic              memDrop;
  logic              conflict;
  logic              writeNext;
  logic [ADDR_W-1:0] regNext;
  logic [DATA_W-1:0] dataNext;

  assign conflict = aluValid && memValid;

  // Readies depend only on the valids and the last-granted source.
  always_comb begin
    aluReady  = 1'b0;
    memReady  = 1'b0;
    stateNext = stateReg;
    if (conflict) begin
      if (stateReg == LAST_MEM) begin
        aluReady  = 1'b1;
        stateNext = LAST_ALU;
      end else begin
        memReady  = 1'b1;
        stateNext = LAST_MEM;
      end
    end else if (aluValid) begin
      aluReady  = 1'b1;
      stateNext = LAST_ALU;
    end else if (memValid) begin
      memReady  = 1'b1;
      stateNext = LAST_MEM;
    end
  end

  assign aluXfer = aluValid && aluReady;
  assign memXfer = memValid && memReady;
  assign aluDrop = ZERO_REG_RO && (aluReg == '0);
  assign memDrop = ZERO_REG_RO && (memReg == '0);

  // Discarded register-0 writes leave the staged index/data untouched.
  always_comb begin
    writeNext = 1'b0;
    regNext   = writeRegister;
    dataNext  = writeData;
    if (aluXfer && !aluDrop) begin
      writeNext = 1'b1;
      regNext   = aluReg;
      dataNext  = aluData;
    end else if (memXfer && !memDrop) begin
      writeNext = 1'b1;
      regNext   = memReg;
      dataNext  = memData;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateReg      <= LAST_MEM;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      conflictCount <= '0;
    end else begin
      stateReg      <= stateNext;
      regWrite      <= writeNext;
      writeRegister <= regNext;
      writeData     <= dataNext;
      if (conflict && (conflictCount != {CNT_W{1'b1}})) begin
        conflictCount <= conflictCount + CNT_W'(1);
      end
    end
  end

`ifdef RFARB_FORWARD_EN
  logic [ADDR_W-1:0] readRegisterArr [2];
  logic              fwdHitArr [2];

  assign readRegisterArr[0] = readRegister1;
  assign readRegisterArr[1] = readRegister2;

  // Register 0 never forwards: it reads as its fixed value.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gFwd
      assign fwdHitArr[gi] = regWrite && (writeRegister == readRegisterArr[gi])
                             && (readRegisterArr[gi] != '0);
    end
  endgenerate

  assign fwdHit1  = fwdHitArr[0];
  assign fwdHit2  = fwdHitArr[1];
  assign fwdData1 = writeData;
  assign fwdData2 = writeData;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus queues expected writes, a monitor checks them.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              resetN;
  logic              aluValid;
  logic [ADDR_W-1:0] aluReg;
  logic [DATA_W-1:0] aluData;
  logic              aluReady;
  logic              memValid;
  logic [ADDR_W-1:0] memReg;
  logic [DATA_W-1:0] memData;
  logic              memReady;
  logic              regWrite;
  logic [ADDR_W-1:0] writeRegister;
  logic [DATA_W-1:0] writeData;
  logic [CNT_W-1:0]  conflictCount;
`ifdef RFARB_FORWARD_EN
  logic [ADDR_W-1:0] readRegister1;
  logic [ADDR_W-1:0] readRegister2;
  logic              fwdHit1;
  logic              fwdHit2;
  logic [DATA_W-1:0] fwdData1;
  logic [DATA_W-1:0] fwdData2;
`endif

  regfile_write_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W(CNT_W),
    .ZERO_REG_RO(1'b1)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .aluValid(aluValid),
    .aluReg(aluReg),
    .aluData(aluData),
    .aluReady(aluReady),
    .memValid(memValid),
    .memReg(memReg),
    .memData(memData),
    .memReady(memReady),
`ifdef RFARB_FORWARD_EN
    .readRegister1(readRegister1),
    .readRegister2(readRegister2),
    .fwdHit1(fwdHit1),
    .fwdHit2(fwdHit2),
    .fwdData1(fwdData1),
    .fwdData2(fwdData2),
`endif
    .regWrite(regWrite),
    .writeRegister(writeRegister),
    .writeData(writeData),
    .conflictCount(conflictCount)
  );

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } expWrite_t;

  expWrite_t         expQ [$];
  logic [DATA_W-1:0] tbRf [32];
  int                compared = 0;
  int                mismatched = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic aV, input logic [ADDR_W-1:0] aR, input logic [DATA_W-1:0] aD,
                       input logic mV, input logic [ADDR_W-1:0] mR, input logic [DATA_W-1:0] mD);
    aluValid = aV; aluReg = aR; aluData = aD;
    memValid = mV; memReg = mR; memData = mD;
  endtask

  task automatic pushExp(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    expWrite_t e;
    e.r = r;
    e.d = d;
    expQ.push_back(e);
  endtask

  // Monitor: every register file write must match the oldest expected write.
  always @(negedge clk) begin
    if (resetN === 1'b1 && regWrite === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpected_write", 64'(regWrite), 64'd0);
      end else begin
        expWrite_t e;
        e = expQ.pop_front();
        check("wr_reg", 64'(writeRegister), 64'(e.r));
        check("wr_data", 64'(writeData), 64'(e.d));
        tbRf[writeRegister] = writeData;
      end
    end
  end

  initial begin
    resetN = 1'b0;
`ifdef RFARB_FORWARD_EN
    readRegister1 = '0;
    readRegister2 = '0;
`endif
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    repeat (3) step();
    check("rst_regWrite", 64'(regWrite), 64'd0);
    check("rst_conflict", 64'(conflictCount), 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    resetN = 1'b1;
    step();

    // Same destination conflict from reset state: ALU first, then MEM.
    drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    #1;
    check("t5_aluReady", 64'(aluReady), 64'd1);
    check("t5_memReady", 64'(memReady), 64'd0);
    pushExp(5'd7, 32'hA);
    step();
    aluValid = 1'b0;
    #1;
    check("t5_memReady2", 64'(memReady), 64'd1);
    pushExp(5'd7, 32'hB);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("t5_conflict", 64'(conflictCount), 64'd1);

    // ALU only, one-cycle latency.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    check("t2_aluReady", 64'(aluReady), 64'd1);
    check("t2_memReady", 64'(memReady), 64'd0);
    pushExp(5'd5, 32'hDEADBEEF);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("t2_regWrite", 64'(regWrite), 64'd1);
    check("t2_writeRegister", 64'(writeRegister), 64'd5);
    check("t2_writeData", 64'(writeData), 64'hDEADBEEF);
    step();
    check("t2_regWrite_off", 64'(regWrite), 64'd0);
    check("t2_hold_data", 64'(writeData), 64'hDEADBEEF);

    // MEM only.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
    #1;
    check("mem_memReady", 64'(memReady), 64'd1);
    pushExp(5'd3, 32'h33);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset right after a transfer drops the staged write.
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    step();
    resetN = 1'b0;
    #1;
    check("rst_drop_regWrite", 64'(regWrite), 64'd0);
    check("rst_drop_data", 64'(writeData), 64'd0);
    check("rst_drop_reg", 64'(writeRegister), 64'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    resetN = 1'b1;
    step();
    check("t3_conflict_start", 64'(conflictCount), 64'd0);

    // Four conflict cycles alternate ALU, MEM, ALU, MEM.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_aluReady", 64'(aluReady), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("t3_memReady", 64'(memReady), (i % 2 == 0) ? 64'd0 : 64'd1);
      if (i % 2 == 0) pushExp(5'd1, 32'h11);
      else pushExp(5'd2, 32'h22);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("t3_conflict", 64'(conflictCount), 64'd4);

    // Register 0 handshake completes but nothing is written.
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
    #1;
    check("t4_aluReady", 64'(aluReady), 64'd1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("t4_regWrite", 64'(regWrite), 64'd0);
    step();

`ifdef RFARB_FORWARD_EN
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0);
    pushExp(5'd9, 32'h55);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    readRegister1 = 5'd9;
    readRegister2 = 5'd0;
    #1;
    check("t6_fwdHit1", 64'(fwdHit1), 64'd1);
    check("t6_fwdData1", 64'(fwdData1), 64'h55);
    check("t6_fwdHit2", 64'(fwdHit2), 64'd0);
    step();
    check("t6_fwdHit1_off", 64'(fwdHit1), 64'd0);
`endif

    // Counter saturation: 20 conflicts to register 0 on top of 4.
    drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2);
    repeat (20) step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("sat_conflict", 64'(conflictCount), 64'd15);
    check("sat_no_write", 64'(regWrite), 64'd0);

    repeat (3) step();
    check("queue_empty", 64'(expQ.size()), 64'd0);
    check("final_r7", 64'(tbRf[7]), 64'hB);
    check("final_r5", 64'(tbRf[5]), 64'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
